// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and write-mode encodings for the register file scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    WM_WORD = 2'd0,
    WM_HALF = 2'd1,
    WM_BYTE = 2'd2,
    WM_NONE = 2'd3
  } wr_mode_e;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read/write/reservation bus between a pipeline front end and the register file scoreboard.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_LEN = DEF_ADDR_LEN
) ();

  logic [ADDR_LEN-1:0] rd_addr_a;
  logic [ADDR_LEN-1:0] rd_addr_b;
  logic                rd_en_a;
  logic                rd_en_b;
  logic [WIDTH-1:0]    rd_data_a;
  logic [WIDTH-1:0]    rd_data_b;
  logic                rd_valid_a;
  logic                rd_valid_b;
  logic                rd_stall;
  logic                wr_en;
  logic [ADDR_LEN-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [1:0]          wr_mode;
  logic                wr_sext;
  logic                rsv_en;
  logic [ADDR_LEN-1:0] rsv_addr;
  logic                halt;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output rd_addr_a, rd_addr_b, rd_en_a, rd_en_b,
    output wr_en, wr_addr, wr_data, wr_mode, wr_sext,
    output rsv_en, rsv_addr, halt,
    input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, rd_stall, busy_vec
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, rd_en_a, rd_en_b,
    input  wr_en, wr_addr, wr_data, wr_mode, wr_sext,
    input  rsv_en, rsv_addr, halt,
    output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, rd_stall, busy_vec
  );

endinterface

// File: rtl/rf_wr_extend.sv
// Combinational writeback extender: selects word/halfword/byte and sign- or zero-extends.
module rf_wr_extend
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [1:0]       wr_mode_i,
  input  logic             wr_sext_i,
  output logic [WIDTH-1:0] ext_data_c_o
);

  always_comb begin
    ext_data_c_o = '0;
    case (wr_mode_e'(wr_mode_i))
      WM_WORD: ext_data_c_o = wr_data_i;
      WM_HALF: ext_data_c_o = {{(WIDTH-16){wr_sext_i & wr_data_i[15]}}, wr_data_i[15:0]};
      WM_BYTE: ext_data_c_o = {{(WIDTH-8){wr_sext_i & wr_data_i[7]}}, wr_data_i[7:0]};
      default: ext_data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a busy scoreboard, write bypass and stall reporting.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_LEN = DEF_ADDR_LEN,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [WIDTH-1:0]    rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]    rd_data_b_q, rd_data_b_d;
  logic                rd_valid_a_q, rd_valid_a_d;
  logic                rd_valid_b_q, rd_valid_b_d;
  logic                rd_stall_q, rd_stall_d;
  logic                stall_a, stall_b;
  logic [WIDTH-1:0]    wr_ext;
  logic                wr_act, rsv_act;

  // A "live" address names a real, writable register (not R0 when hardwired, not out of range).
  function automatic logic addr_live(input logic [ADDR_LEN-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  rf_wr_extend #(.WIDTH(WIDTH)) u_ext (
    .wr_data_i    (bus.wr_data),
    .wr_mode_i    (bus.wr_mode),
    .wr_sext_i    (bus.wr_sext),
    .ext_data_c_o (wr_ext)
  );

  assign wr_act  = bus.wr_en && !bus.halt && (bus.wr_mode != WM_NONE) && addr_live(bus.wr_addr);
  assign rsv_act = bus.rsv_en && !bus.halt && addr_live(bus.rsv_addr);

  // One read port: bypass a same-cycle write, otherwise stall on a busy source.
  function automatic void read_port(
    input  logic                en,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [WIDTH-1:0]    data_q,
    output logic [WIDTH-1:0]    data_d,
    output logic                valid_d,
    output logic                stall
  );
    data_d  = data_q;
    valid_d = 1'b0;
    stall   = 1'b0;
    if (en) begin
      if (!addr_live(addr)) begin
        data_d  = '0;
        valid_d = 1'b1;
      end else if (wr_act && (bus.wr_addr == addr)) begin
        data_d  = wr_ext;
        valid_d = 1'b1;
      end else if (busy_q[addr]) begin
        stall = 1'b1;
      end else begin
        data_d  = regs_q[addr];
        valid_d = 1'b1;
      end
    end
  endfunction

  always_comb begin
    regs_d       = regs_q;
    busy_d       = busy_q;
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    rd_valid_a_d = rd_valid_a_q;
    rd_valid_b_d = rd_valid_b_q;
    rd_stall_d   = rd_stall_q;
    stall_a      = 1'b0;
    stall_b      = 1'b0;
    if (!bus.halt) begin
      read_port(bus.rd_en_a, bus.rd_addr_a, rd_data_a_q, rd_data_a_d, rd_valid_a_d, stall_a);
      read_port(bus.rd_en_b, bus.rd_addr_b, rd_data_b_q, rd_data_b_d, rd_valid_b_d, stall_b);
      rd_stall_d = stall_a | stall_b;
      if (wr_act) begin
        regs_d[bus.wr_addr] = wr_ext;
        busy_d[bus.wr_addr] = 1'b0;
      end
      // Applied after the write so a same-cycle reservation keeps the register busy.
      if (rsv_act) begin
        busy_d[bus.rsv_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_stall_q   <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      rd_stall_q   <= rd_stall_d;
    end
  end

  assign bus.rd_data_a  = rd_data_a_q;
  assign bus.rd_data_b  = rd_data_b_q;
  assign bus.rd_valid_a = rd_valid_a_q;
  assign bus.rd_valid_b = rd_valid_b_q;
  assign bus.rd_stall   = rd_stall_q;
  assign bus.busy_vec   = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a behavioural reference model checked every cycle.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 20;
  localparam int unsigned AL = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.WIDTH(W), .NUM_REGS(NR), .ADDR_LEN(AL)) bus ();

  regfile_scoreboard #(.WIDTH(W), .NUM_REGS(NR), .ADDR_LEN(AL), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference model state
  logic [W-1:0]  m_regs [NR];
  logic [NR-1:0] m_busy;
  logic [W-1:0]  m_da, m_db;
  logic          m_va, m_vb, m_st;

  function automatic logic [W-1:0] ext(input logic [W-1:0] d, input logic [1:0] mode, input logic sx);
    logic [W-1:0] v;
    case (mode)
      2'd0: v = d;
      2'd1: begin v = d & 32'h0000_FFFF; if (sx && v >= 32'h8000) v = v - 32'h1_0000; end
      2'd2: begin v = d & 32'h0000_00FF; if (sx && v >= 32'h80) v = v - 32'h100; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void mread(input logic en, input logic [AL-1:0] addr, input logic [W-1:0] prev,
                                input logic wr_ok, input logic [W-1:0] wv,
                                output logic [W-1:0] d, output logic v, output logic s);
    d = prev; v = 1'b0; s = 1'b0;
    if (!en) return;
    if (addr == 0 || int'(addr) >= int'(NR)) begin d = '0; v = 1'b1; end
    else if (wr_ok && addr == bus.wr_addr) begin d = wv; v = 1'b1; end
    else if (m_busy[addr]) s = 1'b1;
    else begin d = m_regs[addr]; v = 1'b1; end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic         wr_ok, va, vb, sa, sb;
    logic [W-1:0] wv, da, db;
    if (!rst_n) begin
      for (int i = 0; i < int'(NR); i++) m_regs[i] <= '0;
      m_busy <= '0;
      m_da <= '0; m_db <= '0; m_va <= 1'b0; m_vb <= 1'b0; m_st <= 1'b0;
    end else if (!bus.halt) begin
      wr_ok = bus.wr_en && bus.wr_mode != 2'd3 && bus.wr_addr != 0 && int'(bus.wr_addr) < int'(NR);
      wv    = ext(bus.wr_data, bus.wr_mode, bus.wr_sext);
      mread(bus.rd_en_a, bus.rd_addr_a, m_da, wr_ok, wv, da, va, sa);
      mread(bus.rd_en_b, bus.rd_addr_b, m_db, wr_ok, wv, db, vb, sb);
      m_da <= da; m_va <= va; m_db <= db; m_vb <= vb; m_st <= sa | sb;
      if (wr_ok) begin
        m_regs[bus.wr_addr] <= wv;
        m_busy[bus.wr_addr] <= 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != 0 && int'(bus.rsv_addr) < int'(NR))
        m_busy[bus.rsv_addr] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_rd_data_a", 64'(bus.rd_data_a), 64'(m_da));
    chk("cyc_rd_data_b", 64'(bus.rd_data_b), 64'(m_db));
    chk("cyc_rd_valid_a", 64'(bus.rd_valid_a), 64'(m_va));
    chk("cyc_rd_valid_b", 64'(bus.rd_valid_b), 64'(m_vb));
    chk("cyc_rd_stall", 64'(bus.rd_stall), 64'(m_st));
    chk("cyc_busy_vec", 64'(bus.busy_vec), 64'(m_busy));
  end

  task automatic idle();
    bus.rd_en_a = 1'b0; bus.rd_addr_a = '0;
    bus.rd_en_b = 1'b0; bus.rd_addr_b = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mode = 2'd0; bus.wr_sext = 1'b0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.halt = 1'b0;
  endtask

  task automatic rd_a(input int a); bus.rd_en_a = 1'b1; bus.rd_addr_a = AL'(a); endtask
  task automatic rd_b(input int a); bus.rd_en_b = 1'b1; bus.rd_addr_b = AL'(a); endtask
  task automatic rsv(input int a);  bus.rsv_en = 1'b1; bus.rsv_addr = AL'(a); endtask
  task automatic wr(input int a, input logic [W-1:0] d, input logic [1:0] m, input logic sx);
    bus.wr_en = 1'b1; bus.wr_addr = AL'(a); bus.wr_data = d; bus.wr_mode = m; bus.wr_sext = sx;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid_a", 64'(bus.rd_valid_a), 64'd0);
    chk("reset_busy", 64'(bus.busy_vec), 64'd0);
    #10 rst_n = 1'b1;
    step();

    idle(); rd_a(5); step();
    chk("r5_data", 64'(bus.rd_data_a), 64'd0);
    chk("r5_valid", 64'(bus.rd_valid_a), 64'd1);

    idle(); wr(3, 32'h0000_00F0, 2'd2, 1'b1); step();
    idle(); rd_a(3); step();
    chk("r3_byte_sext", 64'(bus.rd_data_a), 64'hFFFF_FFF0);
    idle(); wr(3, 32'h0000_00F0, 2'd2, 1'b0); step();
    idle(); rd_a(3); step();
    chk("r3_byte_zext", 64'(bus.rd_data_a), 64'h0000_00F0);

    idle(); rsv(7); step();
    chk("r7_busy_set", 64'(bus.busy_vec[7]), 64'd1);
    chk("no_req_valid", 64'(bus.rd_valid_a), 64'd0);
    idle(); rd_a(7); step();
    chk("r7_stall_valid", 64'(bus.rd_valid_a), 64'd0);
    chk("r7_stall", 64'(bus.rd_stall), 64'd1);
    chk("r7_stall_hold", 64'(bus.rd_data_a), 64'h0000_00F0);
    idle(); rd_a(7); wr(7, 32'h0000_1234, 2'd0, 1'b0); step();
    chk("r7_bypass_data", 64'(bus.rd_data_a), 64'h0000_1234);
    chk("r7_bypass_valid", 64'(bus.rd_valid_a), 64'd1);
    chk("r7_busy_clr", 64'(bus.busy_vec[7]), 64'd0);
    chk("r7_stall_clr", 64'(bus.rd_stall), 64'd0);

    idle(); rsv(9); wr(9, 32'hAABB_CCDD, 2'd0, 1'b0); step();
    chk("r9_busy_wins", 64'(bus.busy_vec[9]), 64'd1);
    chk("r9_data", 64'(dut.regs_q[9]), 64'hAABB_CCDD);

    idle(); wr(0, 32'hDEAD_BEEF, 2'd0, 1'b0); step();
    idle(); rsv(0); step();
    chk("r0_never_busy", 64'(bus.busy_vec[0]), 64'd0);
    idle(); rd_a(0); rd_b(0); step();
    chk("r0_a_data", 64'(bus.rd_data_a), 64'd0);
    chk("r0_b_data", 64'(bus.rd_data_b), 64'd0);
    chk("r0_a_valid", 64'(bus.rd_valid_a), 64'd1);
    chk("r0_b_valid", 64'(bus.rd_valid_b), 64'd1);

    idle(); wr(2, 32'h1234_8765, 2'd1, 1'b1); rd_b(2); step();
    chk("r2_half_sext_byp", 64'(bus.rd_data_b), 64'hFFFF_8765);
    idle(); wr(2, 32'h1234_8765, 2'd1, 1'b0); rd_a(2); rd_b(2); step();
    chk("r2_half_zext_a", 64'(bus.rd_data_a), 64'h0000_8765);
    chk("r2_half_zext_b", 64'(bus.rd_data_b), 64'h0000_8765);
    idle(); wr(2, 32'hFFFF_FFFF, 2'd3, 1'b1); step();
    idle(); rd_a(2); step();
    chk("r2_mode3_nowrite", 64'(bus.rd_data_a), 64'h0000_8765);

    idle(); wr(25, 32'h77, 2'd0, 1'b0); rsv(25); rd_a(25); step();
    chk("oor_data", 64'(bus.rd_data_a), 64'd0);
    chk("oor_valid", 64'(bus.rd_valid_a), 64'd1);
    chk("oor_busy", 64'(bus.busy_vec), 64'h0_0200);

    idle(); rd_a(3); rd_b(9); step();
    chk("pre_halt_stall", 64'(bus.rd_stall), 64'd1);
    idle(); bus.halt = 1'b1; wr(4, 32'h5555, 2'd0, 1'b0); rsv(4); rd_a(2); rd_b(7); step();
    chk("halt_data_a", 64'(bus.rd_data_a), 64'h0000_00F0);
    chk("halt_valid_a", 64'(bus.rd_valid_a), 64'd1);
    chk("halt_stall", 64'(bus.rd_stall), 64'd1);
    chk("halt_busy", 64'(bus.busy_vec), 64'h0_0200);
    idle(); rd_a(4); step();
    chk("r4_unchanged", 64'(bus.rd_data_a), 64'd0);
    chk("r4_valid", 64'(bus.rd_valid_a), 64'd1);

    idle(); rd_a(3); step();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_data_a", 64'(bus.rd_data_a), 64'd0);
    chk("rst_valid_a", 64'(bus.rd_valid_a), 64'd0);
    chk("rst_data_b", 64'(bus.rd_data_b), 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    idle();
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", 64'(bus.rd_valid_a), 64'd0);
    idle(); rd_a(3); step();
    chk("post_rst_r3", 64'(bus.rd_data_a), 64'd0);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
